fib_arbiter: RTL
================

Name: fib_arbiter

Overview:
Round-robin arbiter and sequencer that shares a single Fibonacci engine between NUM_REQ requesters. Each requester has its own valid/ready request channel and its own response valid/ready. The arbiter grants one requester at a time, issues its operand to the engine, collects the result and returns it to the owner. Exactly one job is in flight at any time. The block sits between client logic and the engine.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
INPUT_WIDTH, 8, operand width; matches the engine input width
OUTPUT_WIDTH, 32, result width; matches the engine output width
ID_WIDTH, $clog2(NUM_REQ), localparam, width of the owner id / round-robin pointer

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
req_vld  in  NUM_REQ  per-requester request valid
req_rdy  out  NUM_REQ  per-requester request ready (one-hot or zero)
req_fib_in  in  NUM_REQ*INPUT_WIDTH  flattened operands; requester i at bits [i*INPUT_WIDTH +: INPUT_WIDTH]
rsp_vld  out  NUM_REQ  per-requester response valid (one-hot or zero)
rsp_rdy  in  NUM_REQ  per-requester response ready
rsp_fib_out  out  OUTPUT_WIDTH  shared result bus, meaningful for the rsp_vld bit that is set
eng_fib_in  out  INPUT_WIDTH  operand to engine
eng_vld_in  out  1  operand valid to engine
eng_rdy_in  in  1  engine ready for operand
eng_fib_out  in  OUTPUT_WIDTH  engine result
eng_vld_out  in  1  engine result valid
eng_rdy_out  out  1  arbiter ready for result
busy  out  1  high in every state other than ARB
owner_id  out  ID_WIDTH  id of the current/last granted requester
done_cnt  out  16  completed jobs, wraps 0xFFFF->0

Behaviour:
- States (fib_pkg::arb_state_t):
  - ARB: arbitrate among requesters.
  - ISSUE: present the operand to the engine.
  - WAIT: wait for the engine result.
  - RETURN: hold the response for the owner.
- Reset (async, rst=1):
  - State and register values: state=ARB, rr_ptr=0, owner_id=0, op_reg=0, res_reg=0, done_cnt=0.
  - Outputs: req_rdy, rsp_vld, eng_vld_in and eng_rdy_out are all 0. req_rdy is gated by !rst.
- ARB:
  - Winner = first i with req_vld[i]=1, searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - req_rdy[winner]=1 combinationally; all other req_rdy bits are 0. No requests means req_rdy=0.
  - On the handshake: op_reg<=operand[winner], owner_id<=winner, rr_ptr<=(winner+1) mod NUM_REQ, next state ISSUE.
  - Requesters must not make req_vld depend on req_rdy. Once asserted, req_vld and its operand are held until accepted.
- ISSUE:
  - eng_vld_in=1, eng_fib_in=op_reg.
  - On eng_rdy_in=1, go to WAIT. Otherwise stay, with eng_vld_in held and the operand stable.
- WAIT:
  - eng_rdy_out=1.
  - On eng_vld_out=1: res_reg<=eng_fib_out, go to RETURN.
- RETURN:
  - rsp_vld[owner_id]=1, rsp_fib_out=res_reg.
  - On rsp_rdy[owner_id]=1: done_cnt<=done_cnt+1, go to ARB.
  - rsp_rdy bits of non-owners are ignored.
- Outside RETURN: rsp_vld=0 and rsp_fib_out=res_reg (stale, don't-care).
- eng_fib_in is driven from op_reg in all states; eng_vld_in is high only in ISSUE.
- Minimum request-accept to rsp_vld: ARB(accept) -> ISSUE -> WAIT -> RETURN, i.e. 3 cycles plus engine compute time.
- Throughput: one job per pass. Requests are never accepted outside ARB, so back-pressure on rsp_rdy stalls all requesters.
- Fairness: a requester with req_vld held is granted within NUM_REQ grants.
- Operands 0 and 1 are handled by the engine (results 0 and 1). The arbiter does not special-case them.
- Reset mid-operation: any in-flight job is discarded and no response is produced. The system resets the engine in the same cycle; the engine's active-low reset is derived at top level.
- Undefined state encoding: next state is ARB.

Decomposition:
- fib_pkg:
  - arb_state_t enum {ARB, ISSUE, WAIT, RETURN}, encoded in logic [1:0].
  - Default width constants FIB_INPUT_WIDTH=8 and FIB_OUTPUT_WIDTH=32.
- One sub-module, rr_picker: purely combinational.
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot grant, winner id, any_req.
  - Implemented by rotate, priority-encode, un-rotate.
- The FSM, operand/result registers and done_cnt stay in fib_arbiter.

Test Plan:
- Single requester 2, operand 10, all rsp_rdy=1 -> rsp_vld[2] with rsp_fib_out=55; done_cnt=1; rr_ptr=3.
- Requesters 0..3 assert simultaneously with operands 5,6,7,8 from reset -> responses in order 0,1,2,3 with values 5,8,13,21; done_cnt=4.
- req_vld[0] and req_vld[2] held continuously, 6 jobs -> grant sequence 0,2,0,2,0,2; neither requester is ever granted twice in a row.
- Requester 1, operand 0, then operand 1 -> rsp_fib_out 0, then 1.
- rsp_rdy[owner] held low for 5 cycles in RETURN -> rsp_vld and rsp_fib_out are stable for those cycles; req_rdy stays 0 while another requester is waiting; that requester is accepted the cycle after the owner's handshake completes.
- rst pulsed during WAIT -> immediately state=ARB, busy=0, rsp_vld=0, eng_rdy_out=0, done_cnt=0, rr_ptr=0; no response for the discarded job; the next request completes correctly.

Source files
------------

// File: rtl/fib_pkg.sv
// Shared types and default widths for the Fibonacci engine arbiter.
// Imported by the arbiter top and its round-robin picker.
package fib_pkg;

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    RETURN = 2'd3
  } arb_state_t;

  localparam int FIB_INPUT_WIDTH  = 8;
  localparam int FIB_OUTPUT_WIDTH = 32;

  // Both operands stay below n, so one conditional subtract replaces a modulo.
  function automatic int wrap_idx(input int idx, input int n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker, zero latency: rotate requests so rr_ptr sits at bit 0,
// take the lowest set bit, rotate the result back. No internal backpressure.
module rr_picker
  import fib_pkg::*;
#(
  parameter int  NUM_REQ  = 4,
  localparam int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] rr_ptr,
  output logic [NUM_REQ-1:0]  grant,
  output logic [ID_WIDTH-1:0] winner,
  output logic                any_req
);

  logic [NUM_REQ-1:0]  rotated;
  logic [ID_WIDTH-1:0] offset;

  always_comb begin
    rotated = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      rotated[j] = req[ID_WIDTH'(wrap_idx(int'(rr_ptr) + j, NUM_REQ))];
    end
  end

  // Scanning downwards leaves the lowest set bit of the rotated vector in offset.
  always_comb begin
    offset  = '0;
    any_req = 1'b0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (rotated[j]) begin
        offset  = ID_WIDTH'(j);
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    winner = ID_WIDTH'(wrap_idx(int'(rr_ptr) + int'(offset), NUM_REQ));
    grant  = '0;
    if (any_req) begin
      grant[winner] = 1'b1;
    end
  end

endmodule

// File: rtl/fib_arbiter.sv
// Shares one Fibonacci engine among NUM_REQ requesters, one job in flight; accept to
// rsp_vld is 3 cycles plus engine time. A stalled response blocks all new requests.
module fib_arbiter
  import fib_pkg::*;
#(
  parameter int  NUM_REQ      = 4,
  parameter int  INPUT_WIDTH  = FIB_INPUT_WIDTH,
  parameter int  OUTPUT_WIDTH = FIB_OUTPUT_WIDTH,
  localparam int ID_WIDTH     = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_vld,
  output logic [NUM_REQ-1:0]             req_rdy,
  input  logic [NUM_REQ*INPUT_WIDTH-1:0] req_fib_in,
  output logic [NUM_REQ-1:0]             rsp_vld,
  input  logic [NUM_REQ-1:0]             rsp_rdy,
  output logic [OUTPUT_WIDTH-1:0]        rsp_fib_out,
  output logic [INPUT_WIDTH-1:0]         eng_fib_in,
  output logic                           eng_vld_in,
  input  logic                           eng_rdy_in,
  input  logic [OUTPUT_WIDTH-1:0]        eng_fib_out,
  input  logic                           eng_vld_out,
  output logic                           eng_rdy_out,
  output logic                           busy,
  output logic [ID_WIDTH-1:0]            owner_id,
  output logic [15:0]                    done_cnt
);

  arb_state_t              state;
  logic [ID_WIDTH-1:0]     rr_ptr;
  logic [ID_WIDTH-1:0]     winner;
  logic [ID_WIDTH-1:0]     next_ptr;
  logic [NUM_REQ-1:0]      grant;
  logic [NUM_REQ-1:0]      owner_oh;
  logic                    any_req;
  logic                    accept;
  logic [INPUT_WIDTH-1:0]  operand [NUM_REQ];
  logic [INPUT_WIDTH-1:0]  op_reg;
  logic [OUTPUT_WIDTH-1:0] res_reg;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      operand[i] = req_fib_in[i*INPUT_WIDTH +: INPUT_WIDTH];
    end
  end

  rr_picker #(
    .NUM_REQ(NUM_REQ)
  ) u_picker (
    .req    (req_vld),
    .rr_ptr (rr_ptr),
    .grant  (grant),
    .winner (winner),
    .any_req(any_req)
  );

  // Ready is a pure function of state and req_vld, never of anything the requester sees first.
  assign req_rdy  = (state == ARB && !rst) ? grant : '0;
  assign accept   = (state == ARB) && any_req;
  assign next_ptr = (int'(winner) == NUM_REQ - 1) ? '0 : winner + ID_WIDTH'(1);

  always_comb begin
    owner_oh           = '0;
    owner_oh[owner_id] = 1'b1;
  end

  assign eng_fib_in  = op_reg;
  assign rsp_fib_out = res_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ARB;
      rr_ptr      <= '0;
      owner_id    <= '0;
      op_reg      <= '0;
      res_reg     <= '0;
      done_cnt    <= '0;
      eng_vld_in  <= 1'b0;
      eng_rdy_out <= 1'b0;
      rsp_vld     <= '0;
      busy        <= 1'b0;
    end else begin
      case (state)
        ARB: begin
          if (accept) begin
            op_reg     <= operand[winner];
            owner_id   <= winner;
            rr_ptr     <= next_ptr;
            eng_vld_in <= 1'b1;
            busy       <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (eng_rdy_in) begin
            eng_vld_in  <= 1'b0;
            eng_rdy_out <= 1'b1;
            state       <= WAIT;
          end
        end
        WAIT: begin
          if (eng_vld_out) begin
            res_reg     <= eng_fib_out;
            eng_rdy_out <= 1'b0;
            rsp_vld     <= owner_oh;
            state       <= RETURN;
          end
        end
        RETURN: begin
          // Only the owner's ready matters; other rsp_rdy bits are don't-care here.
          if (rsp_rdy[owner_id]) begin
            done_cnt <= done_cnt + 16'd1;
            rsp_vld  <= '0;
            busy     <= 1'b0;
            state    <= ARB;
          end
        end
        default: begin
          eng_vld_in  <= 1'b0;
          eng_rdy_out <= 1'b0;
          rsp_vld     <= '0;
          busy        <= 1'b0;
          state       <= ARB;
        end
      endcase
    end
  end

endmodule
